// File: rtl/smc777_kbd_if.sv
// smc777_kbd_if: Z80 I/O window between the SMC-777 core and the keyboard
// front end (two registers, read/write strobes and a level interrupt).
interface smc777_kbd_if;
    logic       cpu_rd;
    logic       cpu_wr;
    logic       cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       key_irq;

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_din,
        input  cpu_dout, key_irq
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_din,
        output cpu_dout, key_irq
    );
endinterface

// File: rtl/smc777_kbd.sv
// smc777_kbd: PS/2 set-2 front end for the SMC-777 core. Translates make codes
// to BIOS character codes, tracks Shift/Ctrl and buffers codes in an 8-deep FIFO.
module smc777_kbd (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    smc777_kbd_if.slave bus
);
    logic       init_q, init_d;
    logic       prev10_q, prev10_d;
    logic       lsh_q, lsh_d;
    logic       rsh_q, rsh_d;
    logic       ctl_q, ctl_d;
    logic       push_q, push_d;
    logic [7:0] code_q, code_d;
    logic       modv_q, modv_d;
    logic [1:0] msel_q, msel_d;
    logic       mmk_q, mmk_d;
    logic [7:0] mem_q [8];
    logic [7:0] mem_d [8];
    logic [2:0] wptr_q, wptr_d;
    logic [2:0] rptr_q, rptr_d;
    logic [3:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       irq_en_q, irq_en_d;

    logic       ev, mk, e0, shift, is_mod, is_let, is_dig;
    logic [7:0] sc, base, xlat, status;
    logic       empty, full, pop, flush, do_push, st_rd, ctl_wr;
    logic       unused_din;

    assign sc     = ps2_key[7:0];
    assign e0     = ps2_key[8];
    assign mk     = ps2_key[9];
    assign ev     = init_q && (ps2_key[10] != prev10_q);
    assign shift  = lsh_q | rsh_q;
    assign is_mod = (!e0 && (sc == 8'h12 || sc == 8'h59)) || sc == 8'h14;

    // Unshifted code for each supported make; zero means "not a key we emit".
    always_comb begin
        base = 8'h00;
        unique case (sc)
            8'h1C: base = 8'h61;
            8'h32: base = 8'h62;
            8'h21: base = 8'h63;
            8'h23: base = 8'h64;
            8'h24: base = 8'h65;
            8'h2B: base = 8'h66;
            8'h34: base = 8'h67;
            8'h33: base = 8'h68;
            8'h43: base = 8'h69;
            8'h3B: base = 8'h6A;
            8'h42: base = 8'h6B;
            8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D;
            8'h31: base = 8'h6E;
            8'h44: base = 8'h6F;
            8'h4D: base = 8'h70;
            8'h15: base = 8'h71;
            8'h2D: base = 8'h72;
            8'h1B: base = 8'h73;
            8'h2C: base = 8'h74;
            8'h3C: base = 8'h75;
            8'h2A: base = 8'h76;
            8'h1D: base = 8'h77;
            8'h22: base = 8'h78;
            8'h35: base = 8'h79;
            8'h1A: base = 8'h7A;
            8'h16: base = 8'h31;
            8'h1E: base = 8'h32;
            8'h26: base = 8'h33;
            8'h25: base = 8'h34;
            8'h2E: base = 8'h35;
            8'h36: base = 8'h36;
            8'h3D: base = 8'h37;
            8'h3E: base = 8'h38;
            8'h46: base = 8'h39;
            8'h45: base = 8'h30;
            8'h5A: base = 8'h0D;
            8'h29: base = 8'h20;
            8'h76: base = 8'h1B;
            8'h66: base = 8'h08;
            default: base = 8'h00;
        endcase
        if (e0 && sc != 8'h5A) base = 8'h00;
    end

    // Apply modifiers: ctrl beats shift on letters, shift also hits digits 1-9.
    always_comb begin
        is_let = base >= 8'h61;
        is_dig = base >= 8'h31 && base <= 8'h39;
        xlat   = base;
        if (is_let && ctl_q)      xlat = base - 8'h60;
        else if (is_let && shift) xlat = base - 8'h20;
        else if (is_dig && shift) xlat = base - 8'h10;
    end

    // Event capture: first clock after reset only primes prev10.
    always_comb begin
        init_d   = 1'b1;
        prev10_d = ps2_key[10];
        modv_d   = ev && is_mod;
        mmk_d    = mk;
        msel_d   = 2'd2;
        if (!e0 && sc == 8'h12)      msel_d = 2'd0;
        else if (!e0 && sc == 8'h59) msel_d = 2'd1;
        push_d   = ev && mk && !is_mod && base != 8'h00;
        code_d   = xlat;
    end

    // Modifier state follows the registered modifier event one cycle later.
    always_comb begin
        lsh_d = lsh_q;
        rsh_d = rsh_q;
        ctl_d = ctl_q;
        if (modv_q) begin
            unique case (msel_q)
                2'd0:    lsh_d = mmk_q;
                2'd1:    rsh_d = mmk_q;
                default: ctl_d = mmk_q;
            endcase
        end
    end

    assign empty   = count_q == 4'd0;
    assign full    = count_q == 4'd8;
    assign pop     = bus.cpu_rd && !bus.cpu_addr && !empty;
    assign st_rd   = bus.cpu_rd && bus.cpu_addr;
    assign ctl_wr  = bus.cpu_wr && bus.cpu_addr;
    assign flush   = ctl_wr && bus.cpu_din[7];
    assign do_push = push_q && (!full || pop);

    // FIFO, overflow and irq enable; flush overrides any push/pop this cycle.
    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        if (ctl_wr) irq_en_d = bus.cpu_din[0];
        if (flush) begin
            wptr_d  = 3'd0;
            rptr_d  = 3'd0;
            count_d = 4'd0;
            ovf_d   = 1'b0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = code_q;
                wptr_d        = wptr_q + 3'd1;
            end
            if (pop) rptr_d = rptr_q + 3'd1;
            if (do_push && !pop)      count_d = count_q + 4'd1;
            else if (!do_push && pop) count_d = count_q - 4'd1;
            if (st_rd) ovf_d = 1'b0;
            if (push_q && full && !pop) ovf_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q   <= 1'b0;
            prev10_q <= 1'b0;
            lsh_q    <= 1'b0;
            rsh_q    <= 1'b0;
            ctl_q    <= 1'b0;
            push_q   <= 1'b0;
            code_q   <= 8'h00;
            modv_q   <= 1'b0;
            msel_q   <= 2'd0;
            mmk_q    <= 1'b0;
            for (int i = 0; i < 8; i++) mem_q[i] <= 8'h00;
            wptr_q   <= 3'd0;
            rptr_q   <= 3'd0;
            count_q  <= 4'd0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            init_q   <= init_d;
            prev10_q <= prev10_d;
            lsh_q    <= lsh_d;
            rsh_q    <= rsh_d;
            ctl_q    <= ctl_d;
            push_q   <= push_d;
            code_q   <= code_d;
            modv_q   <= modv_d;
            msel_q   <= msel_d;
            mmk_q    <= mmk_d;
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
        end
    end

    assign status = {irq_en_q, 1'b0, ctl_q, shift, 1'b0, ovf_q, full, !empty};
    assign bus.cpu_dout = bus.cpu_addr ? status
                        : (empty ? 8'h00 : mem_q[rptr_q]);
    assign bus.key_irq  = irq_en_q && !empty;
    assign unused_din   = ^bus.cpu_din[6:1];
endmodule

// File: tb/tb_smc777_kbd.sv
// tb_smc777_kbd: directed table, corner sequences and a randomized run
// against a queue-based reference model of the keyboard front end.
module tb_smc777_kbd;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    smc777_kbd_if bus();

    smc777_kbd dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [2:0] mods;
        logic       mk;
        logic       e0;
        logic [7:0] sc;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
        8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44,
        8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
        8'h35, 8'h1A};
    logic [7:0] dig_sc [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [48];

    logic [7:0] mq[$];
    logic       m_lsh, m_rsh, m_ctl, m_ovf, m_irq;

    logic [7:0] d, exp_st, rsc, din;
    logic       rmk, re0;
    logic [8:0] xr;
    int         r;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%02h, want 0x%02h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ev(input logic mk, input logic e0, input logic [7:0] sc);
        ps2_key = {~ps2_key[10], mk, e0, sc};
    endtask

    task automatic key(input logic mk, input logic e0, input logic [7:0] sc);
        send_ev(mk, e0, sc);
        repeat (3) tick();
    endtask

    task automatic peek(input logic a, output logic [7:0] v);
        bus.cpu_addr = a;
        #1;
        v = bus.cpu_dout;
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] v);
        bus.cpu_addr = a;
        bus.cpu_rd   = 1'b1;
        #1;
        v = bus.cpu_dout;
        tick();
        bus.cpu_rd = 1'b0;
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] v);
        bus.cpu_addr = a;
        bus.cpu_din  = v;
        bus.cpu_wr   = 1'b1;
        tick();
        bus.cpu_wr = 1'b0;
    endtask

    function automatic void add(input logic [2:0] mods, input logic mk,
                                input logic e0, input logic [7:0] sc,
                                input logic [7:0] exp);
        vec_t v;
        v.mods = mods;
        v.mk   = mk;
        v.e0   = e0;
        v.sc   = sc;
        v.exp  = exp;
        vecs.push_back(v);
    endfunction

    function automatic logic [8:0] xlate(input logic e0, input logic [7:0] sc,
                                         input logic sh, input logic ct);
        if (sc == 8'h5A) return {1'b1, 8'h0D};
        if (e0) return 9'h000;
        for (int i = 0; i < 26; i++)
            if (let_sc[i] == sc)
                return {1'b1, ct ? 8'(i + 1) : sh ? 8'(8'h41 + i) : 8'(8'h61 + i)};
        for (int i = 0; i < 9; i++)
            if (dig_sc[i] == sc)
                return {1'b1, sh ? 8'(8'h21 + i) : 8'(8'h31 + i)};
        case (sc)
            8'h45:   return {1'b1, 8'h30};
            8'h29:   return {1'b1, 8'h20};
            8'h76:   return {1'b1, 8'h1B};
            8'h66:   return {1'b1, 8'h08};
            default: return 9'h000;
        endcase
    endfunction

    function automatic void model_key(input logic mk, input logic e0,
                                      input logic [7:0] sc);
        logic [8:0] x;
        if (!e0 && sc == 8'h12)      m_lsh = mk;
        else if (!e0 && sc == 8'h59) m_rsh = mk;
        else if (sc == 8'h14)        m_ctl = mk;
        else if (mk) begin
            x = xlate(e0, sc, m_lsh | m_rsh, m_ctl);
            if (x[8]) begin
                if (mq.size() < 8) mq.push_back(x[7:0]);
                else m_ovf = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] m_status();
        return {m_irq, 1'b0, m_ctl, m_lsh | m_rsh, 1'b0, m_ovf,
                mq.size() == 8, mq.size() != 0};
    endfunction

    initial begin
        bus.cpu_rd   = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 1'b0;
        bus.cpu_din  = 8'h00;
        ps2_key      = 11'h400;
        reset_n      = 1'b0;

        for (int i = 0; i < 26; i++) pool[i] = let_sc[i];
        for (int i = 0; i < 9; i++) pool[26 + i] = dig_sc[i];
        pool[35] = 8'h45; pool[36] = 8'h5A; pool[37] = 8'h29;
        pool[38] = 8'h76; pool[39] = 8'h66; pool[40] = 8'h12;
        pool[41] = 8'h59; pool[42] = 8'h14; pool[43] = 8'h12;
        pool[44] = 8'h59; pool[45] = 8'h14; pool[46] = 8'h0E;
        pool[47] = 8'h75;

        add(3'b000, 1, 0, 8'h1C, 8'h61);
        add(3'b000, 1, 0, 8'h1A, 8'h7A);
        add(3'b000, 1, 0, 8'h4D, 8'h70);
        add(3'b000, 1, 0, 8'h16, 8'h31);
        add(3'b000, 1, 0, 8'h46, 8'h39);
        add(3'b000, 1, 0, 8'h45, 8'h30);
        add(3'b000, 1, 0, 8'h5A, 8'h0D);
        add(3'b000, 1, 1, 8'h5A, 8'h0D);
        add(3'b000, 1, 0, 8'h29, 8'h20);
        add(3'b000, 1, 0, 8'h76, 8'h1B);
        add(3'b000, 1, 0, 8'h66, 8'h08);
        add(3'b000, 1, 1, 8'h75, 8'h00);
        add(3'b000, 1, 0, 8'h0E, 8'h00);
        add(3'b000, 0, 0, 8'h1C, 8'h00);
        add(3'b001, 1, 0, 8'h1C, 8'h41);
        add(3'b010, 1, 0, 8'h1A, 8'h5A);
        add(3'b001, 1, 0, 8'h16, 8'h21);
        add(3'b001, 1, 0, 8'h46, 8'h29);
        add(3'b001, 1, 0, 8'h45, 8'h30);
        add(3'b001, 1, 0, 8'h29, 8'h20);
        add(3'b100, 1, 0, 8'h1C, 8'h01);
        add(3'b100, 1, 0, 8'h1A, 8'h1A);
        add(3'b101, 1, 0, 8'h1C, 8'h01);
        add(3'b100, 1, 0, 8'h16, 8'h31);
        add(3'b001, 1, 1, 8'h1C, 8'h00);

        // reset state and first key latency
        tick(); tick();
        peek(0, d); chk("rst_data", d, 8'h00);
        peek(1, d); chk("rst_status", d, 8'h00);
        chk("rst_irq", {7'd0, bus.key_irq}, 8'h00);
        reset_n = 1'b1;
        repeat (4) tick();
        peek(1, d); chk("no_spurious", d, 8'h00);
        send_ev(1, 0, 8'h1C);
        tick();
        peek(1, d); chk("lat_n1", d, 8'h00);
        tick();
        peek(1, d); chk("lat_n2", d, 8'h01);
        cpu_read(0, d); chk("first_data", d, 8'h61);
        peek(1, d); chk("first_empty", d, 8'h00);

        // translation table
        foreach (vecs[i]) begin
            if (vecs[i].mods[0]) key(1, 0, 8'h12);
            if (vecs[i].mods[1]) key(1, 0, 8'h59);
            if (vecs[i].mods[2]) key(1, 0, 8'h14);
            key(vecs[i].mk, vecs[i].e0, vecs[i].sc);
            exp_st = {2'b00, vecs[i].mods[2], vecs[i].mods[0] | vecs[i].mods[1],
                      3'b000, vecs[i].exp != 8'h00};
            peek(1, d); chk($sformatf("tbl%0d_status", i), d, exp_st);
            cpu_read(0, d); chk($sformatf("tbl%0d_data", i), d, vecs[i].exp);
            if (vecs[i].mods[0]) key(0, 0, 8'h12);
            if (vecs[i].mods[1]) key(0, 0, 8'h59);
            if (vecs[i].mods[2]) key(0, 0, 8'h14);
        end

        // shifted letter and digit
        key(1, 0, 8'h12);
        peek(1, d); chk("sh_held", d, 8'h10);
        key(1, 0, 8'h1C);
        key(1, 0, 8'h16);
        peek(1, d); chk("sh_held2", d, 8'h11);
        key(0, 0, 8'h12);
        peek(1, d); chk("sh_released", d, 8'h01);
        key(1, 0, 8'h16);
        cpu_read(0, d); chk("sh_q0", d, 8'h41);
        cpu_read(0, d); chk("sh_q1", d, 8'h21);
        cpu_read(0, d); chk("sh_q2", d, 8'h31);
        peek(1, d); chk("sh_empty", d, 8'h00);

        // ctrl and extended keys
        key(1, 1, 8'h14);
        peek(1, d); chk("ctl_held", d, 8'h20);
        key(1, 0, 8'h1A);
        key(1, 1, 8'h5A);
        key(1, 1, 8'h75);
        key(0, 1, 8'h14);
        peek(1, d); chk("ctl_released", d, 8'h01);
        cpu_read(0, d); chk("ctl_q0", d, 8'h1A);
        cpu_read(0, d); chk("ctl_q1", d, 8'h0D);
        cpu_read(0, d); chk("ctl_empty_read", d, 8'h00);

        // overflow
        repeat (9) key(1, 0, 8'h29);
        peek(1, d); chk("ovf_status", d, 8'h07);
        cpu_read(1, d); chk("ovf_rd1", d, 8'h07);
        cpu_read(1, d); chk("ovf_rd2", d, 8'h03);
        for (int i = 0; i < 8; i++) begin
            cpu_read(0, d); chk($sformatf("ovf_drain%0d", i), d, 8'h20);
        end
        peek(1, d); chk("ovf_empty", d, 8'h00);

        // overflow set wins over a same-cycle STATUS read
        repeat (8) key(1, 0, 8'h29);
        peek(1, d); chk("full_status", d, 8'h03);
        send_ev(1, 0, 8'h29);
        tick();
        cpu_read(1, d); chk("setclr_rd", d, 8'h03);
        peek(1, d); chk("setclr_after", d, 8'h07);
        cpu_read(1, d); chk("setclr_rd2", d, 8'h07);
        peek(1, d); chk("setclr_cleared", d, 8'h03);

        // push and pop together while full
        tick();
        send_ev(1, 0, 8'h1C);
        tick();
        cpu_read(0, d); chk("pp_head", d, 8'h20);
        peek(1, d); chk("pp_status", d, 8'h03);
        for (int i = 0; i < 7; i++) begin
            cpu_read(0, d); chk($sformatf("pp_drain%0d", i), d, 8'h20);
        end
        cpu_read(0, d); chk("pp_last", d, 8'h61);
        peek(1, d); chk("pp_empty", d, 8'h00);

        // irq, flush and flush-vs-push
        cpu_write(1, 8'h01);
        peek(1, d); chk("irq_en_status", d, 8'h80);
        chk("irq_idle", {7'd0, bus.key_irq}, 8'h00);
        send_ev(1, 0, 8'h29);
        tick();
        chk("irq_n1", {7'd0, bus.key_irq}, 8'h00);
        tick();
        chk("irq_n2", {7'd0, bus.key_irq}, 8'h01);
        cpu_write(1, 8'h81);
        chk("irq_flushed", {7'd0, bus.key_irq}, 8'h00);
        peek(1, d); chk("flush_status", d, 8'h80);
        tick(); tick();
        send_ev(1, 0, 8'h29);
        tick();
        cpu_write(1, 8'h81);
        tick();
        peek(1, d); chk("flush_push_status", d, 8'h80);
        chk("flush_push_irq", {7'd0, bus.key_irq}, 8'h00);

        // asynchronous reset mid-operation
        key(1, 0, 8'h1C);
        key(1, 0, 8'h12);
        peek(1, d); chk("pre_rst_status", d, 8'h91);
        chk("pre_rst_irq", {7'd0, bus.key_irq}, 8'h01);
        send_ev(1, 0, 8'h29);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_irq", {7'd0, bus.key_irq}, 8'h00);
        peek(0, d); chk("mid_rst_data", d, 8'h00);
        peek(1, d); chk("mid_rst_status", d, 8'h00);
        tick(); tick();
        reset_n = 1'b1;
        repeat (4) tick();
        peek(1, d); chk("post_rst_status", d, 8'h00);
        chk("post_rst_irq", {7'd0, bus.key_irq}, 8'h00);

        // randomized run against the reference model
        m_lsh = 1'b0; m_rsh = 1'b0; m_ctl = 1'b0;
        m_ovf = 1'b0; m_irq = 1'b0;
        mq.delete();
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                rsc = pool[$urandom_range(0, 47)];
                rmk = ($urandom_range(0, 3) != 0);
                re0 = 1'b0;
                if (rsc == 8'h14 || rsc == 8'h5A || rsc == 8'h75 || rsc == 8'h1C)
                    re0 = 1'($urandom_range(0, 1));
                key(rmk, re0, rsc);
                model_key(rmk, re0, rsc);
            end else if (r < 8) begin
                cpu_read(0, d);
                xr = 9'h000;
                if (mq.size() != 0) xr = {1'b1, mq.pop_front()};
                chk("rnd_data", d, xr[7:0]);
            end else if (r == 8) begin
                cpu_read(1, d);
                chk("rnd_status_rd", d, m_status());
                m_ovf = 1'b0;
            end else begin
                din = 8'($urandom);
                din[7] = ($urandom_range(0, 7) == 0);
                cpu_write(1, din);
                m_irq = din[0];
                if (din[7]) begin
                    mq.delete();
                    m_ovf = 1'b0;
                end
            end
            peek(1, d); chk("rnd_status", d, m_status());
            chk("rnd_irq", {7'd0, bus.key_irq},
                {7'd0, m_irq && mq.size() != 0});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/smc777_kbd.md
# smc777_kbd

Keyboard front end for the SMC-777 core. Sits directly upstream of the `smc777` core and takes the host's 11-bit `ps2_key` event word, which today ends at the `key_strobe` edge detector in the top level. Translates PS/2 set-2 make codes into the 8-bit character codes the SMC-777 BIOS expects and tracks the Shift and Ctrl modifiers. Buffers the codes in an 8-entry FIFO, which the Z80 reads through a two-register I/O window with an optional interrupt request.

## Interface
- No parameters. FIFO depth is fixed at 8.
- `clk` in 1: core clock, 48 MHz in the simulation top. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_key` in 11: host key event word.
  - [10] toggles once per event.
  - [9] is 1 for make, 0 for break.
  - [8] is the E0-extended flag.
  - [7:0] is the scancode.
  - The word is stable whenever [10] changes.
- `cpu_rd` in 1: single-cycle read strobe.
- `cpu_wr` in 1: single-cycle write strobe.
- `cpu_addr` in 1: register select. 0 selects DATA, 1 selects STATUS/CTRL.
- `cpu_din` in 8: write data.
- `cpu_dout` out 8: read data. Combinational from registered state and `cpu_addr`.
- `key_irq` out 1: interrupt request, level, active-high.

## Operation
- **Event detect**
  - `prev10` register holds the last sampled `ps2_key[10]`.
  - An event is flagged when `ps2_key[10] != prev10`.
  - In the first clock after reset deassertion, `prev10` loads the current `ps2_key[10]` and no event is flagged. This prevents a spurious event if [10]=1 at reset.
- **Modifiers**
  - Left Shift is 0x12, Right Shift is 0x59. Both are tracked separately; `shift` = either held.
  - `ctrl` is set by 0x14 with or without E0.
  - Make sets the modifier and break clears it.
  - Modifier events never push to the FIFO.
- **Break events** for all other keys are ignored.
- **Translation of make codes** (other E0 codes are dropped):

  | Key | Scancodes | Code |
  |---|---|---|
  | A–Z | 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A | 0x61–0x7A |
  | 1–9 | 16 1E 26 25 2E 36 3D 3E 46 | 0x31–0x39 |
  | 0 | 45 | 0x30 |
  | Enter | 5A, or E0 5A | 0x0D |
  | Space | 29 | 0x20 |
  | Esc | 76 | 0x1B |
  | Backspace | 66 | 0x08 |

  - All other codes are dropped.
- **Modifier application**
  - `ctrl` on a letter gives 0x01–0x1A, and ctrl takes priority over shift.
  - `shift` on a letter gives 0x41–0x5A.
  - `shift` on digits 1–9 gives 0x21–0x29. `0` is unchanged.
  - Modifiers do not affect any other key.
- **FIFO**
  - 8 entries, 3-bit read/write pointers that wrap from 7 to 0, and a 4-bit `count` in the range 0..8.
- **DATA read** (`cpu_addr`=0)
  - `cpu_dout` is the FIFO head, or 0x00 when empty.
  - `cpu_rd` pops on the clock edge if not empty. A read on an empty FIFO has no effect.
- **STATUS read** (`cpu_addr`=1), bit layout of `cpu_dout`:
  - bit0: not empty.
  - bit1: full.
  - bit2: overflow, sticky.
  - bit4: shift.
  - bit5: ctrl.
  - bit7: `irq_en`.
  - All other bits are 0.
  - `cpu_rd` on STATUS clears overflow at the clock edge.
- **CTRL write** (`cpu_addr`=1, `cpu_wr`)
  - `cpu_din[0]` is latched into `irq_en`.
  - `cpu_din[7]`=1 flushes the FIFO: pointers and count go to 0, overflow clears.
- **Writes to DATA** are ignored.
- **Interrupt:** `key_irq` = `irq_en` AND (`count` != 0), decoded from registers so it is glitch-free.

## Timing
- **Latency**
  - An event is detected in cycle N. The translated code is registered at the end of N. The FIFO push happens at the end of N+1.
  - STATUS bit0 and `key_irq` reflect the new entry from cycle N+2.
  - Modifier state updates at the end of N+1.
- **Input spacing:** events are at least 3 clocks apart. This is guaranteed by the host and is not checked.
- **Reset values**
  - `prev10`, `shift`, `ctrl`, `irq_en`, overflow, pointers and `count` are all 0.
  - `cpu_dout` is 0x00 for either address.
  - `key_irq` is 0.
- **Full FIFO:** a push with `count`=8 and no pop in the same cycle drops the code and sets overflow.
- **Push and pop in the same cycle:** both are performed and `count` is unchanged. This includes when `count`=8, in which case the push is accepted.
- **Overflow set and STATUS read in the same cycle:** set wins, so overflow remains 1.
- **Flush and push in the same cycle:** flush wins, and the pushed code is dropped. `count`=0 afterwards.
- **`cpu_rd` and `cpu_wr` in the same cycle:** both take effect.
- **Reset mid-operation:** an asynchronous `reset_n` low returns all state to reset values immediately. An event pending in the pipeline is lost.

## Test plan
- **Reset and basic key:**
  - Stimulus: release reset with `ps2_key`=0x400, then apply {~[10], 1, 0, 0x1C}.
  - Required: no push from the reset value itself. STATUS=0x01 at N+2. DATA reads 0x61. After the pop, STATUS=0x00.
- **Shifted letter and digit:**
  - Stimulus: make 0x12, make 0x1C, make 0x16, break 0x12, make 0x16.
  - Required: FIFO holds 0x41, 0x21, 0x31. STATUS bit4 is 1 only between the shift make and break.
- **Ctrl and extended keys:**
  - Stimulus: E0 make 0x14, make 0x1A, E0 make 0x5A, E0 make 0x75.
  - Required: FIFO holds 0x1A, 0x0D. The E0 0x75 event is dropped.
- **Overflow:**
  - Stimulus: 9 make 0x29 events, then a STATUS read, then a second STATUS read.
  - Required: STATUS=0x07 after the 9th event. The second read returns 0x03. Eight 0x20 entries remain.
- **Simultaneous push/pop when full:**
  - Stimulus: with `count`=8, assert a DATA `cpu_rd` in push cycle N+1.
  - Required: `count` stays 8, overflow stays 0, and the last entry is the new code.
- **IRQ and flush:**
  - Stimulus: write 0x01 to CTRL, push one key, then write 0x81 to CTRL.
  - Required: `key_irq` rises at N+2. After the flush write, `key_irq`=0 and STATUS=0x80.
  - Also: assert `reset_n` low mid-sequence and check all outputs go to 0 in the same cycle.
